// File: rtl/preg_free_list_if.sv
// Rename/retire side of the physical-register free list: alloc requests, grants, releases, status.
// dup_err exists only when FL_DUP_CHECK_EN is defined.
interface preg_free_list_if #(
    parameter int TAG_W = 6
);
    logic             alloc_req_1;
    logic             alloc_req_2;
    logic             alloc_gnt;
    logic [TAG_W-1:0] alloc_tag_1;
    logic [TAG_W-1:0] alloc_tag_2;
    logic             rel_vld_1;
    logic [TAG_W-1:0] rel_tag_1;
    logic             rel_vld_2;
    logic [TAG_W-1:0] rel_tag_2;
    logic [TAG_W-1:0] free_cnt;
    logic             ready;
    logic             ovf_err;
`ifdef FL_DUP_CHECK_EN
    logic             dup_err;

    modport master (
        output alloc_req_1, alloc_req_2, rel_vld_1, rel_tag_1, rel_vld_2, rel_tag_2,
        input  alloc_gnt, alloc_tag_1, alloc_tag_2, free_cnt, ready, ovf_err, dup_err
    );
    modport slave (
        input  alloc_req_1, alloc_req_2, rel_vld_1, rel_tag_1, rel_vld_2, rel_tag_2,
        output alloc_gnt, alloc_tag_1, alloc_tag_2, free_cnt, ready, ovf_err, dup_err
    );
`else
    modport master (
        output alloc_req_1, alloc_req_2, rel_vld_1, rel_tag_1, rel_vld_2, rel_tag_2,
        input  alloc_gnt, alloc_tag_1, alloc_tag_2, free_cnt, ready, ovf_err
    );
    modport slave (
        input  alloc_req_1, alloc_req_2, rel_vld_1, rel_tag_1, rel_vld_2, rel_tag_2,
        output alloc_gnt, alloc_tag_1, alloc_tag_2, free_cnt, ready, ovf_err
    );
`endif
endinterface

// File: rtl/preg_free_list.sv
// Circular free list of physical tags, 2 allocs + 2 releases per cycle; grant/tags are a same-cycle peek,
// all-or-nothing grant stalls rename. FL_DUP_CHECK_EN adds a duplicate-release filter and dup_err.
module preg_free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int TAG_W     = $clog2(NUM_PREGS),
    parameter int DEPTH     = NUM_PREGS - NUM_AREGS
) (
    input logic             clk,
    input logic             rst,
    preg_free_list_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t           state;
    logic             ready_q;
    logic             ovf_q;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [TAG_W-1:0] count;
    logic [TAG_W-1:0] mem [DEPTH];

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
        logic [PTR_W+1:0] s;
        s = {2'b00, p} + {{PTR_W{1'b0}}, n};
        if (s >= (PTR_W+2)'(DEPTH))
            s = s - (PTR_W+2)'(DEPTH);
        return s[PTR_W-1:0];
    endfunction

    logic [1:0]       nreq;
    logic             gnt;
    logic [PTR_W-1:0] head1;
    logic [PTR_W-1:0] tail1;

    assign nreq  = {1'b0, bus.alloc_req_1} + {1'b0, bus.alloc_req_2};
    assign gnt   = ready_q && (nreq != 2'd0) && (count >= TAG_W'(nreq));
    assign head1 = wrap_add(head, 2'd1);
    assign tail1 = wrap_add(tail, 2'd1);

    assign bus.alloc_gnt   = gnt;
    assign bus.alloc_tag_1 = (gnt && bus.alloc_req_1) ? mem[head] : '0;
    assign bus.alloc_tag_2 = (gnt && bus.alloc_req_2) ? (bus.alloc_req_1 ? mem[head1] : mem[head]) : '0;
    assign bus.free_cnt    = count;
    assign bus.ready       = ready_q;
    assign bus.ovf_err     = ovf_q;

    // Release candidates: tag 0 is the pinned x0 mapping and never enters the list.
    logic rel_ok_1, rel_ok_2;
`ifdef FL_DUP_CHECK_EN
    logic [NUM_PREGS-1:0] in_list;
    logic                 dup_q;
    logic                 dup_hit;
    logic                 same_tag;

    assign same_tag = bus.rel_vld_1 && (bus.rel_tag_1 == bus.rel_tag_2);
    assign rel_ok_1 = bus.rel_vld_1 && (bus.rel_tag_1 != '0) && !in_list[bus.rel_tag_1];
    assign rel_ok_2 = bus.rel_vld_2 && (bus.rel_tag_2 != '0) && !in_list[bus.rel_tag_2] && !same_tag;
    assign dup_hit  = ready_q && (
                      (bus.rel_vld_1 && (bus.rel_tag_1 != '0) && in_list[bus.rel_tag_1]) ||
                      (bus.rel_vld_2 && (bus.rel_tag_2 != '0) && (in_list[bus.rel_tag_2] || same_tag)));
    assign bus.dup_err = dup_q;
`else
    assign rel_ok_1 = bus.rel_vld_1 && (bus.rel_tag_1 != '0);
    assign rel_ok_2 = bus.rel_vld_2 && (bus.rel_tag_2 != '0);
`endif

    // Capacity check uses the registered count only; a same-cycle pop does not make room.
    logic acc_1, acc_2, drop;
    assign acc_1 = ready_q && rel_ok_1 && (count < TAG_W'(DEPTH));
    assign acc_2 = ready_q && rel_ok_2 && ((count + {{(TAG_W-1){1'b0}}, acc_1}) < TAG_W'(DEPTH));
    assign drop  = ready_q && ((rel_ok_1 && !acc_1) || (rel_ok_2 && !acc_2));

    logic             we_1, we_2;
    logic [PTR_W-1:0] wa_1, wa_2;
    logic [TAG_W-1:0] wd_1, wd_2;
    logic [1:0]       nacc;

    always_comb begin
        we_1 = acc_1;
        we_2 = acc_2;
        wa_1 = tail;
        wa_2 = acc_1 ? tail1 : tail;
        wd_1 = bus.rel_tag_1;
        wd_2 = bus.rel_tag_2;
        if (state == S_INIT) begin
            we_1 = 1'b1;
            we_2 = 1'b1;
            wa_2 = tail1;
            wd_1 = TAG_W'(NUM_AREGS) + TAG_W'(tail);
            wd_2 = TAG_W'(NUM_AREGS) + TAG_W'(tail) + TAG_W'(1);
        end
    end

    assign nacc = {1'b0, we_1} + {1'b0, we_2};

    always_ff @(posedge clk) begin
        if (we_1) mem[wa_1] <= wd_1;
        if (we_2) mem[wa_2] <= wd_2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_INIT;
            ready_q <= 1'b0;
            ovf_q   <= 1'b0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            tail  <= wrap_add(tail, nacc);
            count <= count + TAG_W'(nacc) - (gnt ? TAG_W'(nreq) : '0);
            if (gnt)
                head <= wrap_add(head, nreq);
            if (drop)
                ovf_q <= 1'b1;
            case (state)
                S_INIT: if (tail == PTR_W'(DEPTH - 2)) begin
                    state   <= S_RUN;
                    ready_q <= 1'b1;
                end
                default: state <= S_RUN;
            endcase
        end
    end

`ifdef FL_DUP_CHECK_EN
    // Pops clear first so a tag popped and rewritten in one cycle stays marked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_list <= '0;
            dup_q   <= 1'b0;
        end else begin
            if (gnt) begin
                in_list[mem[head]] <= 1'b0;
                if (nreq == 2'd2)
                    in_list[mem[head1]] <= 1'b0;
            end
            if (we_1) in_list[wd_1] <= 1'b1;
            if (we_2) in_list[wd_2] <= 1'b1;
            if (dup_hit)
                dup_q <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list: init sequence, paired/single grants, empty/full edges, wrap, reset.
module tb_preg_free_list;
    logic clk = 1'b0;
    logic rst;
    int   vec_cnt = 0;
    int   miscmp_cnt = 0;

    always #5 clk = ~clk;

    preg_free_list_if #(.TAG_W(6)) bus ();

    preg_free_list dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.alloc_req_1 = 1'b0;
        bus.alloc_req_2 = 1'b0;
        bus.rel_vld_1   = 1'b0;
        bus.rel_tag_1   = '0;
        bus.rel_vld_2   = 1'b0;
        bus.rel_tag_2   = '0;
        repeat (2) tick();
        bus.alloc_req_1 = 1'b1;
        #1;
        check_vec("rst_ready", bus.ready, 0);
        check_vec("rst_free_cnt", bus.free_cnt, 0);
        check_vec("rst_gnt", bus.alloc_gnt, 0);
        check_vec("rst_tag1", bus.alloc_tag_1, 0);
        check_vec("rst_ovf", bus.ovf_err, 0);
`ifdef FL_DUP_CHECK_EN
        check_vec("rst_dup", bus.dup_err, 0);
`endif
        bus.alloc_req_1 = 1'b0;
        rst = 1'b0;

        // Sixteen INIT cycles; a release and a request in the middle must be ignored.
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                bus.rel_vld_1 = 1'b1; bus.rel_tag_1 = 6'd7; bus.alloc_req_1 = 1'b1;
                #1;
                check_vec("init_gnt", bus.alloc_gnt, 0);
            end
            check_vec("init_ready", bus.ready, 0);
            tick();
            bus.rel_vld_1 = 1'b0; bus.alloc_req_1 = 1'b0;
        end
        #1;
        check_vec("run_ready", bus.ready, 1);
        check_vec("run_free_cnt", bus.free_cnt, 32);
        check_vec("run_ovf", bus.ovf_err, 0);

        bus.alloc_req_1 = 1'b1;
        #1;
        check_vec("single_gnt", bus.alloc_gnt, 1);
        check_vec("single_tag1", bus.alloc_tag_1, 32);
        check_vec("single_tag2", bus.alloc_tag_2, 0);

        bus.alloc_req_2 = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_vec("pair_gnt", bus.alloc_gnt, 1);
            check_vec("pair_tag1", bus.alloc_tag_1, 32 + 2 * k);
            check_vec("pair_tag2", bus.alloc_tag_2, 33 + 2 * k);
            tick();
            check_vec("pair_free_cnt", bus.free_cnt, 30 - 2 * k);
        end

        // Drain 24 more in pairs, then one single, leaving exactly one free entry (tag 63).
        repeat (12) tick();
        bus.alloc_req_2 = 1'b0;
        #1;
        check_vec("drain_tag1", bus.alloc_tag_1, 62);
        tick();
        check_vec("drain_free_cnt", bus.free_cnt, 1);

        bus.alloc_req_2 = 1'b1;
        #1;
        check_vec("short_gnt", bus.alloc_gnt, 0);
        check_vec("short_tag1", bus.alloc_tag_1, 0);
        check_vec("short_tag2", bus.alloc_tag_2, 0);
        tick();
        check_vec("short_free_cnt", bus.free_cnt, 1);
        bus.alloc_req_1 = 1'b0;
        #1;
        check_vec("slot2_gnt", bus.alloc_gnt, 1);
        check_vec("slot2_tag2", bus.alloc_tag_2, 63);
        check_vec("slot2_tag1", bus.alloc_tag_1, 0);
        tick();
        bus.alloc_req_2 = 1'b0;
        check_vec("empty_free_cnt", bus.free_cnt, 0);

        // Releases into an empty list are not visible to alloc until the next cycle.
        bus.rel_vld_1 = 1'b1; bus.rel_tag_1 = 6'd5;
        bus.rel_vld_2 = 1'b1; bus.rel_tag_2 = 6'd9;
        bus.alloc_req_1 = 1'b1;
        #1;
        check_vec("empty_rel_gnt", bus.alloc_gnt, 0);
        tick();
        bus.rel_vld_1 = 1'b0; bus.rel_vld_2 = 1'b0;
        #1;
        check_vec("rel_free_cnt", bus.free_cnt, 2);
        check_vec("rel_gnt", bus.alloc_gnt, 1);
        check_vec("rel_tag_a", bus.alloc_tag_1, 5);
        tick();
        check_vec("rel_tag_b", bus.alloc_tag_1, 9);
        tick();
        bus.alloc_req_1 = 1'b0;
        check_vec("rel_drained", bus.free_cnt, 0);

        bus.rel_vld_1 = 1'b1; bus.rel_tag_1 = 6'd0;
        tick();
        bus.rel_vld_1 = 1'b0;
        check_vec("tag0_ignored", bus.free_cnt, 0);

        // Fill to 31 with tags 10..40.
        for (int k = 0; k < 15; k++) begin
            bus.rel_vld_1 = 1'b1; bus.rel_tag_1 = 6'(10 + 2 * k);
            bus.rel_vld_2 = 1'b1; bus.rel_tag_2 = 6'(11 + 2 * k);
            tick();
        end
        bus.rel_vld_2 = 1'b0;
        bus.rel_tag_1 = 6'd40;
        tick();
        bus.rel_vld_1 = 1'b0;
        check_vec("fill_free_cnt", bus.free_cnt, 31);
        check_vec("fill_ovf", bus.ovf_err, 0);

        bus.rel_vld_1 = 1'b1; bus.rel_tag_1 = 6'd3;
        bus.rel_vld_2 = 1'b1; bus.rel_tag_2 = 6'd4;
        tick();
        bus.rel_vld_1 = 1'b0; bus.rel_vld_2 = 1'b0;
        check_vec("full_free_cnt", bus.free_cnt, 32);
        check_vec("full_ovf", bus.ovf_err, 1);

        // Drain across the pointer wrap; FIFO order must hold.
        bus.alloc_req_1 = 1'b1;
        #1;
        check_vec("wrap_first", bus.alloc_tag_1, 10);
        tick();
        bus.alloc_req_2 = 1'b1;
        #1;
        for (int k = 0; k < 14; k++) begin
            check_vec("wrap_tag1", bus.alloc_tag_1, 11 + 2 * k);
            check_vec("wrap_tag2", bus.alloc_tag_2, 12 + 2 * k);
            tick();
        end
        check_vec("wrap_edge_tag1", bus.alloc_tag_1, 39);
        check_vec("wrap_edge_tag2", bus.alloc_tag_2, 40);
        tick();
        bus.alloc_req_2 = 1'b0;
        #1;
        check_vec("wrap_last", bus.alloc_tag_1, 3);
        tick();
        bus.alloc_req_1 = 1'b0;
        check_vec("wrap_free_cnt", bus.free_cnt, 0);
        check_vec("wrap_ovf_sticky", bus.ovf_err, 1);

        bus.rel_vld_1 = 1'b1; bus.rel_tag_1 = 6'd40;
        tick();
        check_vec("dup_first", bus.free_cnt, 1);
        tick();
        bus.rel_vld_1 = 1'b0;
`ifdef FL_DUP_CHECK_EN
        check_vec("dup_dropped", bus.free_cnt, 1);
        check_vec("dup_err", bus.dup_err, 1);
`else
        check_vec("dup_enqueued", bus.free_cnt, 2);
`endif

        // Asynchronous reset in the middle of RUN.
        bus.alloc_req_1 = 1'b1;
        rst = 1'b1;
        #1;
        check_vec("midrst_ready", bus.ready, 0);
        check_vec("midrst_free_cnt", bus.free_cnt, 0);
        check_vec("midrst_gnt", bus.alloc_gnt, 0);
        bus.alloc_req_1 = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end
endmodule

// File: doc/preg_free_list.md
Name: preg_free_list

Overview:
- Circular free list of physical register tags for the 2-wide rename stage.
- Hands out up to 2 free physical registers per cycle to rename and stalls rename when not enough are free.
- Takes back up to 2 released tags per cycle from retire.
- Replaces the combinational 64-entry bit scan with a sequenced FIFO that has a reset-time initialisation FSM.

Parameters:
- NUM_PREGS, 64, total physical registers.
- NUM_AREGS, 32, architectural registers; tags 0..NUM_AREGS-1 are mapped at reset.
- TAG_W, 6, physical tag width, equal to log2(NUM_PREGS).
- DEPTH, NUM_PREGS-NUM_AREGS (32), free list capacity in entries.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_req_1  in  1  rename slot 1 needs a destination tag.
- alloc_req_2  in  1  rename slot 2 needs a destination tag.
- alloc_gnt  out  1  all requested tags granted this cycle (combinational).
- alloc_tag_1  out  TAG_W  tag for slot 1 (combinational peek).
- alloc_tag_2  out  TAG_W  tag for slot 2 (combinational peek).
- rel_vld_1  in  1  retire slot 1 releases rel_tag_1.
- rel_tag_1  in  TAG_W  released tag, slot 1.
- rel_vld_2  in  1  retire slot 2 releases rel_tag_2.
- rel_tag_2  in  TAG_W  released tag, slot 2.
- free_cnt  out  TAG_W  registered count of free entries, range 0..DEPTH.
- ready  out  1  initialisation complete.
- ovf_err  out  1  sticky: a release was dropped because the list was full.

Behaviour:
- Storage:
  - DEPTH x TAG_W array, head/tail pointers, registered count.
  - Pointers wrap modulo DEPTH.
- Reset (async):
  - head=0, tail=0, count=0, state=INIT.
  - ready=0, ovf_err=0, alloc_gnt=0, alloc_tag_1/2=0.
  - Array contents are not reset.
- FSM INIT:
  - Each cycle writes tags NUM_AREGS+2k and NUM_AREGS+2k+1 at tail and tail+1; tail+=2, count+=2.
  - After DEPTH/2 cycles (16) moves to RUN, so free_cnt=32 and ready=1 on the first RUN cycle.
  - In INIT: alloc_gnt=0, releases are ignored, ovf_err is unchanged.
- FSM RUN: state is held; there is no exit except rst.
- Requested count: nreq = alloc_req_1 + alloc_req_2.
- Grant: alloc_gnt = ready & (nreq!=0) & (count >= nreq). Grants are all-or-nothing; there is no partial grant.
- Tag outputs:
  - Both slots requesting: alloc_tag_1=array[head], alloc_tag_2=array[head+1].
  - Only slot 1 or only slot 2 requesting: that slot gets array[head]; the other tag output is 0.
  - No grant: both tags are 0.
- Pop: on alloc_gnt, head advances by nreq at the clock edge.
- Releases:
  - rel_tag==0 is ignored (x0 is pinned to p0).
  - Slot 1 is written before slot 2: slot 1 at tail, slot 2 at tail+1 if slot 1 was also accepted, else at tail.
  - A release is accepted only if count plus releases already accepted this cycle is < DEPTH (the same-cycle pop is not counted). Otherwise it is dropped and ovf_err is set.
- Count update: count_next = count + accepted_rel − (alloc_gnt ? nreq : 0).
- Release visibility: released tags are never visible to alloc in the same cycle. Grant uses the registered count only.
- Empty list: count=0 → alloc_gnt=0; count=1 with nreq=2 → alloc_gnt=0, nothing pops.
- Wrap: head/tail of DEPTH-1 plus 2 wraps to 1; tag order is preserved FIFO.
- Reset mid-operation: asynchronously returns to INIT; outstanding allocations are forgotten.

Optional Feature:
- Macro: FL_DUP_CHECK_EN.
- Enabled:
  - Adds an NUM_PREGS-bit in_list bitmap, set on accepted write (including INIT) and cleared on pop.
  - A release whose tag is already in the list, or equal to the other slot's same-cycle tag, is dropped.
  - Adds output dup_err (1 bit, sticky, reset 0), set on any such drop.
- Disabled: no bitmap and no dup_err port; duplicates are enqueued as-is.

Test Plan:
- Reset, no requests → ready=0 for 16 cycles, then ready=1, free_cnt=32, alloc_tag_1=32 when alloc_req_1=1.
- RUN, both requests for 3 cycles → tags (32,33),(34,35),(36,37); free_cnt steps 30,28,26.
- Drain to free_cnt=1, then assert both requests → alloc_gnt=0, free_cnt stays 1. Then only alloc_req_2 → alloc_gnt=1, alloc_tag_2=63, alloc_tag_1=0.
- free_cnt=0 with rel_vld_1 (tag 5) and rel_vld_2 (tag 9) plus alloc_req_1 in the same cycle → no grant that cycle; next cycle alloc_req_1 gives tag 5, then 9.
- free_cnt=31 with both releases (tags 3, 4) → tag 3 accepted, tag 4 dropped, ovf_err=1, free_cnt=32. Release tag 0 → ignored, count unchanged.
- FL_DUP_CHECK_EN: release tag 40 while 40 is in the list → dropped, dup_err=1, free_cnt unchanged.
